// File: rtl/gcd_lcm.sv
// LCM companion to the GCD engine: lcm = (a / g) * b, computed with a
// restoring divider followed by a shift-add multiplier, one bit per cycle.
module gcd_lcm #(
  parameter int GCD_LENGTH = 14
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [GCD_LENGTH-1:0]     in_a,
  input  logic [GCD_LENGTH-1:0]     in_b,
  input  logic [GCD_LENGTH-1:0]     gcd_in,
  input  logic                      gcd_valid,
  output logic [2*GCD_LENGTH-1:0]   lcm,
  output logic                      lcm_valid,
  output logic                      busy,
  output logic                      ovr
);

  localparam int W  = GCD_LENGTH;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, DIV, MUL, DONE} state_t;

  state_t          r_state;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_g;
  logic [W-1:0]    r_dvd;
  logic [W-1:0]    r_rem;
  logic [CW-1:0]   r_cnt;
  logic [2*W-1:0]  r_acc;
  logic [2*W-1:0]  r_mcand;
  logic [W-1:0]    r_mplier;

  logic [W:0]      w_rem_sh;
  logic            w_ge;
  logic [W:0]      w_rem_nx;
  logic [W-1:0]    w_quo;
  logic [2*W-1:0]  w_acc_nx;

  // The stored remainder is always < g, so W bits hold it; the shifted
  // remainder gets one extra bit so the compare against g cannot overflow.
  always_comb begin
    w_rem_sh = {r_rem, r_dvd[W-1]};
    w_ge     = (w_rem_sh >= {1'b0, r_g});
    w_rem_nx = w_ge ? (w_rem_sh - {1'b0, r_g}) : w_rem_sh;
    w_quo    = {r_dvd[W-2:0], w_ge};
    w_acc_nx = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_b       <= '0;
      r_g       <= '0;
      r_dvd     <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      lcm       <= '0;
      lcm_valid <= 1'b0;
      busy      <= 1'b0;
      ovr       <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          lcm_valid <= 1'b0;
          busy      <= 1'b0;
          if (gcd_valid) begin
            r_b   <= in_b;
            r_g   <= gcd_in;
            r_dvd <= in_a;
            r_rem <= '0;
            r_cnt <= CW'(W - 1);
            if (gcd_in == '0) begin
              lcm       <= '0;
              lcm_valid <= 1'b1;
              r_state   <= DONE;
            end else begin
              busy    <= 1'b1;
              r_state <= DIV;
            end
          end else begin
            r_state <= IDLE;
          end
        end

        DIV: begin
          if (gcd_valid) ovr <= 1'b1;
          r_rem <= w_rem_nx[W-1:0];
          r_dvd <= w_quo;
          if (r_cnt == '0) begin
            r_acc    <= '0;
            r_mcand  <= {{W{1'b0}}, r_b};
            r_mplier <= w_quo;
            r_cnt    <= CW'(W - 1);
            r_state  <= MUL;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end

        MUL: begin
          if (gcd_valid) ovr <= 1'b1;
          r_acc    <= w_acc_nx;
          r_mcand  <= {r_mcand[2*W-2:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[W-1:1]};
          if (r_cnt == '0) begin
            lcm       <= w_acc_nx;
            lcm_valid <= 1'b1;
            busy      <= 1'b0;
            r_state   <= DONE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_lcm.sv
// Directed bench for gcd_lcm: expected results are queued at each strobe
// and compared (value and arrival cycle) whenever lcm_valid pulses.
module tb_gcd_lcm;

  localparam int W = 14;

  logic             clk;
  logic             rst;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic [W-1:0]     gcd_in;
  logic             gcd_valid;
  logic [2*W-1:0]   lcm;
  logic             lcm_valid;
  logic             busy;
  logic             ovr;

  gcd_lcm #(.GCD_LENGTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_a      (in_a),
    .in_b      (in_b),
    .gcd_in    (gcd_in),
    .gcd_valid (gcd_valid),
    .lcm       (lcm),
    .lcm_valid (lcm_valid),
    .busy      (busy),
    .ovr       (ovr)
  );

  typedef struct {
    logic [63:0] val;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one strobe starting at a falling edge; k is the last rising edge
  // before the strobe, so results are due after edge k+1 or k+2W+1.
  task automatic strobe(input int a, input int b, input int g, input bit push, output int k);
    exp_t e;
    in_a      = W'(a);
    in_b      = W'(b);
    gcd_in    = W'(g);
    gcd_valid = 1'b1;
    k = cyc;
    if (push) begin
      e.val = (g == 0) ? 64'd0 : 64'((a / g) * b);
      e.cyc = (g == 0) ? k + 1 : k + 2 * W + 1;
      q.push_back(e);
    end
    @(negedge clk);
    gcd_valid = 1'b0;
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 64'(q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && lcm_valid) begin
      check("result_expected", 64'(q.size() > 0), 64'd1);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        check("lcm_value", 64'(lcm), e.val);
        check("lcm_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, k2, kd;
    rst = 1'b1;
    in_a = '0;
    in_b = '0;
    gcd_in = '0;
    gcd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_lcm", 64'(lcm), 64'd0);
    check("rst_valid", 64'(lcm_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ovr", 64'(ovr), 64'd0);
    rst = 1'b0;

    // Basic 12,18,6 with busy window and single-cycle valid
    strobe(12, 18, 6, 1'b1, k);
    check("busy_start", 64'(busy), 64'd1);
    wait_to(k + 2 * W);
    check("busy_end", 64'(busy), 64'd1);
    check("valid_early", 64'(lcm_valid), 64'd0);
    wait_to(k + 2 * W + 1);
    check("busy_done", 64'(busy), 64'd0);
    wait_to(k + 2 * W + 2);
    check("valid_fall", 64'(lcm_valid), 64'd0);
    check("lcm_hold", 64'(lcm), 64'd36);
    drain();

    strobe(16383, 16382, 1, 1'b1, k);
    drain();
    strobe(0, 5, 5, 1'b1, k);
    drain();
    strobe(9, 15, 3, 1'b1, k);
    drain();
    strobe(0, 0, 0, 1'b1, k);
    drain();
    strobe(21, 6, 3, 1'b1, k);
    drain();
    strobe(5, 3, 0, 1'b1, k);
    drain();

    // Back-to-back: second strobe lands in the DONE cycle
    strobe(12, 18, 6, 1'b1, k);
    wait_to(k + 2 * W + 1);
    strobe(4, 6, 2, 1'b1, k2);
    drain();
    check("b2b_ovr", 64'(ovr), 64'd0);

    // Overrun: strobe while busy is ignored and flagged
    strobe(12, 18, 6, 1'b1, k);
    wait_to(k + 10);
    strobe(7, 7, 7, 1'b0, k2);
    check("ovr_set", 64'(ovr), 64'd1);
    drain();
    check("ovr_sticky", 64'(ovr), 64'd1);

    // Reset aborts an operation in flight
    strobe(12, 18, 6, 1'b1, k);
    wait_to(k + 5);
    rst = 1'b1;
    #1;
    q.delete();
    check("abort_lcm", 64'(lcm), 64'd0);
    check("abort_valid", 64'(lcm_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_ovr", 64'(ovr), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    kd = cyc;
    wait_to(kd + 2 * W + 5);
    check("abort_quiet_lcm", 64'(lcm), 64'd0);
    strobe(9, 6, 3, 1'b1, k);
    drain();
    check("final_ovr", 64'(ovr), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
